// File: rtl/pipelined_carry_adder.sv
// Add/subtract pipeline: each stage resolves one WIDTH/STAGES-bit carry segment and passes its carry on.
// Define PIPELINED_CARRY_ADDER_SATURATE_EN to clamp overflowing results to the signed limit.
module pipelined_carry_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;
  localparam int MSB  = WIDTH - 1;

  // Stage k registers: operand skew (a, effective b), partial-sum deskew, segment carry, valid.
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q  [STAGES];
  logic [WIDTH-1:0]  bx_q [STAGES];
  logic [WIDTH-1:0]  ps_q [STAGES];
  logic              ovf_q;
  logic              zero_q;

  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_src  [STAGES];
  logic [WIDTH-1:0]  bx_src [STAGES];
  logic [WIDTH-1:0]  ps_src [STAGES];
  logic [WIDTH-1:0]  ps_d   [STAGES];
  logic [SEG:0]      seg_sum [STAGES];
  logic [WIDTH-1:0]  raw_sum;
  logic [WIDTH-1:0]  fin_sum;
  logic              fin_ovf;
  logic              fin_zero;
  logic              a_msb;
  logic              bx_msb;

  assign out_valid = vld_q[LAST];
  assign in_ready  = ~(out_valid & ~out_ready);
  assign sum       = ps_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

  // Subtract is folded in at entry as ~b with a forced carry-in, so later stages only add.
  always_comb begin
    c_src     = '0;
    a_src[0]  = a;
    bx_src[0] = sub ? ~b : b;
    c_src[0]  = sub | cin;
    ps_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]  = a_q[k-1];
      bx_src[k] = bx_q[k-1];
      c_src[k]  = c_q[k-1];
      ps_src[k] = ps_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      seg_sum[k] = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, bx_src[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, c_src[k]};
      ps_d[k] = ps_src[k];
      ps_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      c_d[k] = seg_sum[k][SEG];
    end
    raw_sum = ps_d[LAST];
    a_msb   = a_src[LAST][MSB];
    bx_msb  = bx_src[LAST][MSB];
    fin_ovf = (a_msb ^ raw_sum[MSB]) & ~(a_msb ^ bx_msb);
`ifdef PIPELINED_CARRY_ADDER_SATURATE_EN
    fin_sum = raw_sum;
    if (fin_ovf) begin
      fin_sum = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    fin_sum = raw_sum;
`endif
    fin_zero = (fin_sum == '0);
  end

  // The whole pipe, bubbles included, advances together or freezes together on back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= '0;
        bx_q[k] <= '0;
        ps_q[k] <= '0;
      end
    end else if (in_ready) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]  <= a_src[k];
        bx_q[k] <= bx_src[k];
        ps_q[k] <= ps_d[k];
      end
      c_q        <= c_d;
      ps_q[LAST] <= fin_sum;
      ovf_q      <= fin_ovf;
      zero_q     <= fin_zero;
    end
  end

endmodule

// File: doc/pipelined_carry_adder.md
PIPELINED_CARRY_ADDER -- requirements
Module: pipelined_carry_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal values 2..64).
REQ-002 SHALL have parameter STAGES, default 2, number of pipeline stages (legal values 1..8; WIDTH divisible by STAGES). Each stage handles a WIDTH/STAGES-bit carry segment.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand beat offered.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 SHALL have port cin, input, 1 bit: carry-in (add mode only).
REQ-009 SHALL have port sub, input, 1 bit: 1 selects subtract mode.
REQ-010 SHALL have port out_valid, output, 1 bit: result beat present.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-012 SHALL have port sum, output, WIDTH bits: result.
REQ-013 SHALL have port cout, output, 1 bit: carry-out of MSB.
REQ-014 SHALL have port overflow, output, 1 bit: signed overflow.
REQ-015 SHALL have port zero, output, 1 bit: sum equals 0.

Function
REQ-016 SHALL compute add mode as a + b + cin, modulo 2^WIDTH; cout is bit WIDTH of the full result.
REQ-017 SHALL compute sub mode as a + ~b + 1; cin is ignored; cout=1 means no borrow.
REQ-018 SHALL set overflow = (a[MSB] XOR sum[MSB]) AND NOT (a[MSB] XOR b'[MSB]), where b' is b in add mode and ~b in sub mode; overflow uses the pre-saturation sum.
REQ-019 Stage k SHALL add segment k of the operands with the carry registered from stage k-1. Higher operand segments and the mode bit are carried forward in skew registers. Lower sum segments are carried forward in deskew registers.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted beat (in_valid & in_ready) to out_valid, with no stalls.
REQ-021 Throughput SHALL be one beat per cycle while out_ready=1.
REQ-022 Stall: in_ready = NOT (out_valid AND NOT out_ready). When in_ready=0, every pipeline register (data and valid) SHALL hold.
REQ-023 Bubbles: a cycle with in_valid=0 and in_ready=1 SHALL insert an invalid slot. Bubbles are not collapsed.
REQ-024 While out_valid=1 and out_ready=0, sum, cout, overflow and zero SHALL remain stable.
REQ-025 Data outputs SHALL be don't-care when out_valid=0 but SHALL be deterministic (registered).
REQ-026 Operands accepted while in_ready=0 SHALL be ignored.
REQ-027 There is no ordering change: results SHALL leave in acceptance order.

Reset
REQ-028 rst=1 at a rising edge SHALL clear all valid bits, so out_valid=0 on the next cycle. All data registers, sum, cout, overflow and zero SHALL become 0, and in_ready=1.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result from before reset appears afterwards.
REQ-030 A beat presented in the same cycle as rst=1 SHALL NOT be accepted.

Configuration
REQ-031 Macro PIPELINED_CARRY_ADDER_SATURATE_EN defined: when overflow=1, sum SHALL be clamped to the signed limit (0 MSB with all other bits 1 if a[MSB]=0, else 1 MSB with all other bits 0). cout, overflow and zero SHALL reflect the pre-clamp values, except that zero is computed on the clamped sum.
REQ-032 Macro undefined: sum SHALL wrap modulo 2^WIDTH; no clamp logic is present.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-033 SHALL cover: a=0x7F, b=0x01, cin=0, sub=0 -> after 2 cycles sum=0x80, cout=0, overflow=1, zero=0. With the SATURATE macro, sum=0x7F.
REQ-034 SHALL cover: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, overflow=0, zero=1. Also a=0x0F, b=0x00, cin=1 -> sum=0x10 (cross-segment carry).
REQ-035 SHALL cover: a=0x05, b=0x07, sub=1, cin=1 -> sum=0xFE, cout=0, overflow=0. Also a=0x80, b=0x01, sub=1 -> sum=0x7F, overflow=1.
REQ-036 SHALL cover: 4 back-to-back beats with out_ready=0 from cycle 2 for 3 cycles -> in_ready=0 during the stall, outputs stable, and all 4 results emitted in order once out_ready=1.
REQ-037 SHALL cover: rst asserted while 2 beats are in flight -> out_valid=0 next cycle, no stale result ever appears, and a new beat gives a correct result 2 cycles after acceptance.
REQ-038 SHALL cover: random sweep at WIDTH=16, STAGES=4 and WIDTH=8, STAGES=1, with random in_valid/out_ready, compared against a reference model.
